// File: rtl/fetch_predict.sv
`default_nettype none
// ============================================================================
// Module   : fetch_predict
// Purpose  : Fetch-stage PC generator with a bimodal branch history table
//            (2-bit saturating counters) combined with an external BTB.
//            Resolved branches from WB train the BHT, trigger a redirect
//            (flush) on misprediction, and are counted.
//
// Ports    : clk                 - single clock, rising-edge
//            reset               - synchronous, active-high
//            stall               - hold the fetch PC
//            btb_hit/btb_target  - BTB lookup result for pc_if (same cycle)
//            resolve_*           - branch outcome and its carried prediction
//            pc_if               - registered fetch PC
//            pred_taken          - direction prediction for pc_if (comb)
//            flush               - squash younger instructions (comb)
//            br_count            - resolved branches, saturating
//            mispred_count       - mispredictions, saturating
//
// Revision : 1.0 - initial release
// ============================================================================
module fetch_predict #(
    parameter int BHT_LINES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        btb_hit,
    input  logic [15:0] btb_target,
    input  logic        resolve_valid,
    input  logic [15:0] resolve_pc,
    input  logic        resolve_taken,
    input  logic [15:0] resolve_target,
    input  logic        resolve_pred_taken,
    input  logic [15:0] resolve_pred_target,
    output logic [15:0] pc_if,
    output logic        pred_taken,
    output logic        flush,
    output logic [15:0] br_count,
    output logic [15:0] mispred_count
);

    localparam int IDX_W = (BHT_LINES > 1) ? $clog2(BHT_LINES) : 1;

    localparam logic [1:0]  c_CTR_RESET = 2'b01;
    localparam logic [1:0]  c_CTR_MAX   = 2'b11;
    localparam logic [1:0]  c_CTR_MIN   = 2'b00;
    localparam logic [15:0] c_CNT_MAX   = 16'hFFFF;
    localparam logic [15:0] c_PC_STEP   = 16'd2;

    logic [15:0]      r_pc;
    logic [15:0]      r_br_count;
    logic [15:0]      r_mispred_count;
    logic [1:0]       r_bht [BHT_LINES];

    logic [IDX_W-1:0] w_rd_idx;
    logic [IDX_W-1:0] w_wr_idx;
    logic [1:0]       w_rd_ctr;
    logic [1:0]       w_wr_ctr;
    logic [1:0]       w_wr_ctr_next;
    logic             w_pred_taken;
    logic             w_dir_wrong;
    logic             w_tgt_wrong;
    logic             w_mispredict;
    logic [15:0]      w_redirect_pc;
    logic [15:0]      w_pc_sel;
    logic [15:0]      w_pc_next;

    // Halfword-aligned PCs: bit 0 never contributes to the index.
    assign w_rd_idx = r_pc[IDX_W:1];
    assign w_wr_idx = resolve_pc[IDX_W:1];

    // Read the registered table; a same-cycle write lands only at the next
    // edge, so a coinciding lookup naturally sees the pre-update counter.
    assign w_rd_ctr     = r_bht[w_rd_idx];
    assign w_pred_taken = btb_hit & w_rd_ctr[1];

    // Target mismatch only matters when both actual and predicted say taken.
    assign w_dir_wrong  = resolve_taken != resolve_pred_taken;
    assign w_tgt_wrong  = resolve_taken & resolve_pred_taken &
                          (resolve_target != resolve_pred_target);
    assign w_mispredict = resolve_valid & (w_dir_wrong | w_tgt_wrong);

    assign w_redirect_pc = resolve_taken ? resolve_target
                                         : (resolve_pc + c_PC_STEP);

    // Redirect outranks stall so a mispredict is never lost during a hold.
    always_comb begin
        w_pc_sel = r_pc + c_PC_STEP;
        if (w_mispredict) begin
            w_pc_sel = w_redirect_pc;
        end else if (stall) begin
            w_pc_sel = r_pc;
        end else if (w_pred_taken) begin
            w_pc_sel = btb_target;
        end
    end

    assign w_pc_next = {w_pc_sel[15:1], 1'b0};

    // Counter training value for the entry being resolved.
    assign w_wr_ctr = r_bht[w_wr_idx];

    always_comb begin
        w_wr_ctr_next = w_wr_ctr;
        if (resolve_taken) begin
            if (w_wr_ctr != c_CTR_MAX) begin
                w_wr_ctr_next = w_wr_ctr + 2'd1;
            end
        end else begin
            if (w_wr_ctr != c_CTR_MIN) begin
                w_wr_ctr_next = w_wr_ctr - 2'd1;
            end
        end
    end

    // PC register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= 16'h0000;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // BHT: trained on every resolve regardless of stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_LINES; i++) begin
                r_bht[i] <= c_CTR_RESET;
            end
        end else if (resolve_valid) begin
            r_bht[w_wr_idx] <= w_wr_ctr_next;
        end
    end

    // Statistics counters, saturating.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_br_count      <= 16'h0000;
            r_mispred_count <= 16'h0000;
        end else begin
            if (resolve_valid && (r_br_count != c_CNT_MAX)) begin
                r_br_count <= r_br_count + 16'd1;
            end
            if (w_mispredict && (r_mispred_count != c_CNT_MAX)) begin
                r_mispred_count <= r_mispred_count + 16'd1;
            end
        end
    end

    assign pc_if         = r_pc;
    assign pred_taken    = w_pred_taken;
    assign flush         = w_mispredict;
    assign br_count      = r_br_count;
    assign mispred_count = r_mispred_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_predict.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_predict
// Purpose  : Self-checking bench for fetch_predict: directed scenarios then
//            randomized traffic, compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_predict;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        btb_hit;
    logic [15:0] btb_target;
    logic        resolve_valid;
    logic [15:0] resolve_pc;
    logic        resolve_taken;
    logic [15:0] resolve_target;
    logic        resolve_pred_taken;
    logic [15:0] resolve_pred_target;
    logic [15:0] pc_if;
    logic        pred_taken;
    logic        flush;
    logic [15:0] br_count;
    logic [15:0] mispred_count;

    int n_checks;
    int n_fail;

    // Reference model state
    int m_pc;
    int m_bht [32];
    int m_br;
    int m_mis;

    fetch_predict #(.BHT_LINES(32)) u_dut (
        .clk                 (clk),
        .reset               (reset),
        .stall               (stall),
        .btb_hit             (btb_hit),
        .btb_target          (btb_target),
        .resolve_valid       (resolve_valid),
        .resolve_pc          (resolve_pc),
        .resolve_taken       (resolve_taken),
        .resolve_target      (resolve_target),
        .resolve_pred_taken  (resolve_pred_taken),
        .resolve_pred_target (resolve_pred_target),
        .pc_if               (pc_if),
        .pred_taken          (pred_taken),
        .flush               (flush),
        .br_count            (br_count),
        .mispred_count       (mispred_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc  = 0;
        m_br  = 0;
        m_mis = 0;
        for (int i = 0; i < 32; i++) m_bht[i] = 1;
    endtask

    // One clock cycle: apply inputs at negedge, check combinational outputs,
    // advance the model at posedge, then check registered outputs.
    task automatic cycle(input logic rst, input logic stl, input logic hit,
                         input logic [15:0] tgt, input logic rv,
                         input logic [15:0] rpc, input logic rt,
                         input logic [15:0] rtgt, input logic rpt,
                         input logic [15:0] rptgt);
        bit exp_pred;
        bit exp_mis;
        int nxt;
        int widx;
        @(negedge clk);
        reset               = rst;
        stall               = stl;
        btb_hit             = hit;
        btb_target          = tgt;
        resolve_valid       = rv;
        resolve_pc          = rpc;
        resolve_taken       = rt;
        resolve_target      = rtgt;
        resolve_pred_taken  = rpt;
        resolve_pred_target = rptgt;
        #1;
        exp_pred = hit && (m_bht[(m_pc / 2) % 32] >= 2);
        exp_mis  = rv && ((rt != rpt) || (rt && rpt && (rtgt != rptgt)));
        chk("pred_taken", {31'd0, pred_taken}, {31'd0, exp_pred});
        if (!rst) chk("flush", {31'd0, flush}, {31'd0, exp_mis});
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (exp_mis)        nxt = rt ? int'(rtgt) : (int'(rpc) + 2);
            else if (stl)       nxt = m_pc;
            else if (exp_pred)  nxt = int'(tgt);
            else                nxt = m_pc + 2;
            m_pc = (nxt % 65536) & 32'hFFFE;
            if (rv) begin
                widx = (int'(rpc) / 2) % 32;
                if (rt) m_bht[widx] = (m_bht[widx] == 3) ? 3 : m_bht[widx] + 1;
                else    m_bht[widx] = (m_bht[widx] == 0) ? 0 : m_bht[widx] - 1;
                if (m_br < 65535) m_br++;
            end
            if (exp_mis && m_mis < 65535) m_mis++;
        end
        #1;
        chk("pc_if", {16'd0, pc_if}, m_pc);
        chk("br_count", {16'd0, br_count}, m_br);
        chk("mispred_count", {16'd0, mispred_count}, m_mis);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    endtask

    initial begin
        logic [15:0] r_tgt;
        logic [15:0] r_rpc;
        logic [15:0] r_rtgt;
        logic [15:0] r_ptgt;
        logic        r_rt;
        logic        r_pt;
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1; stall = 1'b0; btb_hit = 1'b0; btb_target = 16'h0;
        resolve_valid = 1'b0; resolve_pc = 16'h0; resolve_taken = 1'b0;
        resolve_target = 16'h0; resolve_pred_taken = 1'b0; resolve_pred_target = 16'h0;
        @(posedge clk);
        model_reset();

        // Reset state, then sequential fetch
        cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
        chk("rst_pc", {16'd0, pc_if}, 32'h0000);
        chk("rst_br", {16'd0, br_count}, 32'h0);
        idle(); idle(); idle();
        chk("seq_pc", {16'd0, pc_if}, 32'h0006);

        // Train entry for 0x0010 (correctly predicted, no redirect)
        cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0010, 1'b1, 16'h0040, 1'b1, 16'h0040);
        cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0010, 1'b1, 16'h0040, 1'b1, 16'h0040);
        idle(); idle(); idle();
        chk("at_0010", {16'd0, pc_if}, 32'h0010);
        cycle(1'b0, 1'b0, 1'b1, 16'h0040, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
        chk("btb_redirect", {16'd0, pc_if}, 32'h0040);
        chk("br_after_train", {16'd0, br_count}, 32'd2);

        // Mispredict during stall still redirects
        cycle(1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0030, 1'b1, 16'h0100, 1'b0, 16'h0);
        chk("stall_redirect", {16'd0, pc_if}, 32'h0100);
        chk("mis_cnt", {16'd0, mispred_count}, 32'd1);

        // Wrong target, then correct not-taken
        cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0008, 1'b1, 16'h0204, 1'b1, 16'h0200);
        chk("tgt_redirect", {16'd0, pc_if}, 32'h0204);
        cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h000A, 1'b0, 16'h0, 1'b0, 16'h0);
        chk("nt_no_mis", {16'd0, mispred_count}, 32'd2);

        // Wraparound; redirect via pc 0 also trains entry 0 to 10
        cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 16'h0);
        chk("at_fffe", {16'd0, pc_if}, 32'hFFFE);
        idle();
        chk("wrap", {16'd0, pc_if}, 32'h0000);
        cycle(1'b0, 1'b0, 1'b1, 16'h0031, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
        chk("odd_tgt", {16'd0, pc_if}, 32'h0030);

        // Reset mid-stream with a mispredicting resolve to pc 0x0020
        cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0020, 1'b1, 16'h0500, 1'b0, 16'h0);
        chk("midrst_pc", {16'd0, pc_if}, 32'h0000);
        chk("midrst_mis", {16'd0, mispred_count}, 32'd0);
        for (int i = 0; i < 16; i++) idle();
        cycle(1'b0, 1'b0, 1'b1, 16'h0600, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
        chk("midrst_bht", {16'd0, pc_if}, 32'h0022);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            r_tgt  = 16'($urandom);
            r_rpc  = 16'($urandom) & 16'h007E;
            r_rt   = 1'($urandom);
            r_rtgt = 16'($urandom);
            r_pt   = ($urandom_range(0, 9) < 7) ? r_rt : ~r_rt;
            r_ptgt = ($urandom_range(0, 9) < 7) ? r_rtgt : 16'($urandom);
            cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0),
                  1'($urandom), r_tgt, ($urandom_range(0, 2) != 0), r_rpc,
                  r_rt, r_rtgt, r_pt, r_ptgt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
